// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM: sequences fetch/decode/execute phases and
// faults on illegal opcodes or a memory access that stalls past TIMEOUT_CYCLES.
module multicycle_controller #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [6:0] i_op,
   input  logic       i_zero,
   input  logic       i_mem_ready,
   output logic       o_mem_req,
   output logic       o_mem_write,
   output logic       o_adr_src,
   output logic       o_ir_write,
   output logic       o_pc_write,
   output logic       o_reg_write,
   output logic [1:0] o_result_src,
   output logic [1:0] o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [1:0] o_ALUOp,
   output logic [3:0] o_state,
   output logic       o_fault
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      ALUWB    = 4'd7,
      EXECUTEI = 4'd8,
      JAL      = 4'd9,
      BEQ      = 4'd10,
      FAULT    = 4'd11
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] wait_reg, wait_next;
   logic          waiting;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= FETCH;
         wait_reg  <= '0;
      end else begin
         state_reg <= state_next;
         wait_reg  <= wait_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      waiting      = 1'b0;
      o_mem_req    = 1'b0;
      o_mem_write  = 1'b0;
      o_adr_src    = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_write   = 1'b0;
      o_reg_write  = 1'b0;
      o_result_src = 2'b00;
      o_alu_src_a  = 2'b00;
      o_alu_src_b  = 2'b00;
      o_ALUOp      = 2'b00;
      o_fault      = 1'b0;
      case (state_reg)
         FETCH: begin
            o_mem_req    = 1'b1;
            o_alu_src_b  = 2'b10;
            o_result_src = 2'b10;
            o_ir_write   = i_mem_ready;
            o_pc_write   = i_mem_ready;
            waiting      = ~i_mem_ready;
            if (i_mem_ready) state_next = DECODE;
         end
         DECODE: begin
            o_alu_src_a = 2'b01;
            o_alu_src_b = 2'b01;
            case (i_op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_R:         state_next = EXECUTER;
               OP_I:         state_next = EXECUTEI;
               OP_JAL:       state_next = JAL;
               OP_BEQ:       state_next = BEQ;
               default:      state_next = FAULT;
            endcase
         end
         MEMADR: begin
            o_alu_src_a = 2'b10;
            o_alu_src_b = 2'b01;
            state_next  = (i_op == OP_LW) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            o_mem_req = 1'b1;
            o_adr_src = 1'b1;
            waiting   = ~i_mem_ready;
            if (i_mem_ready) state_next = MEMWB;
         end
         MEMWB: begin
            o_result_src = 2'b01;
            o_reg_write  = 1'b1;
            state_next   = FETCH;
         end
         MEMWRITE: begin
            o_mem_req   = 1'b1;
            o_mem_write = 1'b1;
            o_adr_src   = 1'b1;
            waiting     = ~i_mem_ready;
            if (i_mem_ready) state_next = FETCH;
         end
         EXECUTER: begin
            o_alu_src_a = 2'b10;
            o_ALUOp     = 2'b10;
            state_next  = ALUWB;
         end
         EXECUTEI: begin
            o_alu_src_a = 2'b10;
            o_alu_src_b = 2'b01;
            o_ALUOp     = 2'b10;
            state_next  = ALUWB;
         end
         ALUWB: begin
            o_reg_write = 1'b1;
            state_next  = FETCH;
         end
         JAL: begin
            o_alu_src_a = 2'b01;
            o_alu_src_b = 2'b10;
            o_pc_write  = 1'b1;
            state_next  = ALUWB;
         end
         BEQ: begin
            o_alu_src_a = 2'b10;
            o_ALUOp     = 2'b01;
            o_pc_write  = i_zero;
            state_next  = FETCH;
         end
         FAULT: begin
            o_fault = 1'b1;
         end
         default: state_next = FAULT;
      endcase

      // A completing access (ready) in the final tolerated cycle wins over the timeout.
      if (waiting && (wait_reg == TIMEOUT_VAL)) state_next = FAULT;

      if (state_next != state_reg) wait_next = '0;
      else if (waiting)            wait_next = wait_reg + CW'(1);
      else                         wait_next = wait_reg;
   end

   assign o_state = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-instruction reference model pushes the expected output
// vector for every cycle; a negedge monitor pops and compares against the DUT.
module tb_multicycle_controller;

   localparam int TIMEOUT = 15;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef struct packed {
      logic [3:0] state;
      logic       mem_req;
      logic       mem_write;
      logic       adr_src;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_a;
      logic [1:0] alu_b;
      logic [1:0] aluop;
      logic       fault;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [6:0] op;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, fault;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic [3:0] state;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   multicycle_controller #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_op         (op),
      .i_zero       (zero),
      .i_mem_ready  (mem_ready),
      .o_mem_req    (mem_req),
      .o_mem_write  (mem_write),
      .o_adr_src    (adr_src),
      .o_ir_write   (ir_write),
      .o_pc_write   (pc_write),
      .o_reg_write  (reg_write),
      .o_result_src (result_src),
      .o_alu_src_a  (alu_src_a),
      .o_alu_src_b  (alu_src_b),
      .o_ALUOp      (alu_op),
      .o_state      (state),
      .o_fault      (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs of a state, straight from the per-state output table.
   function automatic exp_t expect_out(input int s, input bit rdy, input bit z);
      exp_t e;
      e = '0;
      e.state = 4'(s);
      case (s)
         0:  begin e.mem_req = 1; e.alu_b = 2; e.result_src = 2; e.ir_write = rdy; e.pc_write = rdy; end
         1:  begin e.alu_a = 1; e.alu_b = 1; end
         2:  begin e.alu_a = 2; e.alu_b = 1; end
         3:  begin e.mem_req = 1; e.adr_src = 1; end
         4:  begin e.result_src = 1; e.reg_write = 1; end
         5:  begin e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; end
         6:  begin e.alu_a = 2; e.alu_b = 0; e.aluop = 2; end
         7:  begin e.reg_write = 1; end
         8:  begin e.alu_a = 2; e.alu_b = 1; e.aluop = 2; end
         9:  begin e.alu_a = 1; e.alu_b = 2; e.pc_write = 1; end
         10: begin e.alu_a = 2; e.aluop = 1; e.pc_write = z; end
         11: begin e.fault = 1; end
         default: ;
      endcase
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = '{state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, fault};
         n_vec++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL cycle_outputs t=%0t: got state=%0d vec=%h, required state=%0d vec=%h",
                     $time, a.state, a, e.state, e);
         end
      end
   end

   task automatic check(input string name, input bit ok);
      if (!ok) begin
         n_bad++;
         $display("FAIL %s t=%0t: state=%0d fault=%0b mem_req=%0b mem_write=%0b aluop=%0d reg_write=%0b",
                  name, $time, state, fault, mem_req, mem_write, alu_op, reg_write);
      end
   endtask

   // One clock cycle: apply inputs, record what the DUT must show this cycle.
   task automatic step(input int s, input bit rdy, input bit r);
      mem_ready = rdy;
      rst       = r;
      exp_q.push_back(expect_out(s, rdy, zero));
      @(posedge clk);
      #1;
   endtask

   task automatic step_any(input int s);
      step(s, 1'($urandom_range(0, 1)), 1'b0);
   endtask

   // A memory-wait state lasting w stall cycles; stalls beyond TIMEOUT fault.
   task automatic mem_phase(input int s, input int w, output bit faulted);
      faulted = 1'b0;
      for (int c = 0; c <= w; c++) begin
         step(s, (c == w), 1'b0);
         if (c != w && c == TIMEOUT) begin
            check("expired_wait", (state === 4'd11) && (fault === 1'b1));
            faulted = 1'b1;
            return;
         end
      end
   endtask

   task automatic fault_then_reset(input int hold);
      for (int i = 0; i < hold; i++) step_any(11);
      step(11, 1'($urandom_range(0, 1)), 1'b1);
      check("fault_reset", (state === 4'd0) && (fault === 1'b0));
   endtask

   task automatic run_instr(input logic [6:0] o, input bit z, input int wf, input int wm, input int hold);
      bit f;
      op   = o;
      zero = z;
      mem_phase(0, wf, f);
      if (f) begin fault_then_reset(hold); return; end
      step_any(1);
      case (o)
         OP_LW: begin
            step_any(2);
            mem_phase(3, wm, f);
            if (f) fault_then_reset(hold);
            else   step_any(4);
         end
         OP_SW: begin
            step_any(2);
            mem_phase(5, wm, f);
            if (f) fault_then_reset(hold);
         end
         OP_R:    begin step_any(6); step_any(7); end
         OP_I:    begin step_any(8); step_any(7); end
         OP_JAL:  begin step_any(9); step_any(7); end
         OP_BEQ:  step_any(10);
         default: fault_then_reset(hold);
      endcase
   endtask

   initial begin
      logic [6:0] ops [6];
      bit f;
      ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
      op = OP_R; zero = 1'b0; mem_ready = 1'b0; rst = 1'b1;
      @(posedge clk);
      #1;
      step(0, 1'b0, 1'b1);                // reset state held in FETCH
      check("reset_state", (state === 4'd0) && (mem_req === 1'b1) && (alu_op === 2'b00) &&
                           (reg_write === 1'b0) && (mem_write === 1'b0) && (fault === 1'b0));

      run_instr(OP_R,   1'b0, 0, 0, 1);   // 0,1,6,7
      run_instr(OP_LW,  1'b0, 0, 2, 1);   // 0,1,2,3,3,3,4
      run_instr(OP_BEQ, 1'b1, 0, 0, 1);
      run_instr(OP_BEQ, 1'b0, 0, 0, 1);
      run_instr(7'b1111111, 1'b0, 0, 0, 20);
      run_instr(OP_R,   1'b0, 16, 0, 3);  // FETCH timeout
      run_instr(OP_R,   1'b0, 15, 0, 3);  // ready on the 16th FETCH cycle
      run_instr(OP_SW,  1'b0, 1, 16, 2);  // MEMWRITE timeout
      run_instr(OP_LW,  1'b0, 0, 15, 2);  // MEMREAD boundary

      // Reset asserted mid-wait in MEMWRITE; wait counter must restart.
      op = OP_SW;
      mem_phase(0, 0, f);
      step_any(1);
      step_any(2);
      step(5, 1'b0, 1'b0);
      step(5, 1'b0, 1'b0);
      step(5, 1'b0, 1'b1);
      check("midwait_reset", (state === 4'd0) && (mem_write === 1'b0));
      run_instr(OP_R, 1'b0, 15, 0, 2);
      run_instr(OP_R, 1'b0, 16, 0, 2);

      for (int n = 0; n < 120; n++) begin
         logic [6:0] o;
         int wf, wm;
         if ($urandom_range(0, 7) == 0) o = 7'($urandom);
         else                           o = ops[$urandom_range(0, 5)];
         wf = ($urandom_range(0, 15) == 0) ? $urandom_range(15, 16) : $urandom_range(0, 3);
         wm = ($urandom_range(0, 9) == 0)  ? $urandom_range(15, 16) : $urandom_range(0, 3);
         run_instr(o, 1'($urandom_range(0, 1)), wf, wm, $urandom_range(1, 4));
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
